// File: rtl/rtc_pkg.sv
// Shared types and constants for the uPD4990 serial sequencer.
package rtc_pkg;

  localparam int TIME_W = 48;

  localparam logic [5:0] BITS_TIME = 6'd47;
  localparam logic [5:0] BITS_CMD  = 6'd3;

  localparam logic [3:0] RTC_HOLD     = 4'h0;
  localparam logic [3:0] RTC_SHIFT    = 4'h1;
  localparam logic [3:0] RTC_TIMESET  = 4'h2;
  localparam logic [3:0] RTC_TIMEREAD = 4'h3;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_BIT_LO = 3'd2,
    ST_BIT_HI = 3'd3,
    ST_PRE    = 3'd4,
    ST_STB    = 3'd5,
    ST_POST   = 3'd6,
    ST_FINISH = 3'd7
  } state_e;

  // Op code 3 is an alias of the command-only request.
  function automatic op_e decode_op(input logic [1:0] op);
    case (op)
      2'd1:    decode_op = OP_WRITE;
      2'd2:    decode_op = OP_READ;
      default: decode_op = OP_CMD;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bit_timer.sv
// Loadable 8-bit down-counter; tc is high while the count sits at zero.
module rtc_bit_timer (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc
);

  logic [7:0] count_r;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != 8'd0) begin
      count_r <= count_r - 8'd1;
    end
  end

  assign tc = (count_r == 8'd0);

endmodule

// File: rtl/rtc_serial_ctrl.sv
// Sequencer driving the uPD4990 serial port: command, time write and time read.
module rtc_serial_ctrl
  import rtc_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int STROBE_LEN = 4
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              REQ,
  input  logic [1:0]        OP,
  input  logic [3:0]        CMD,
  input  logic [TIME_W-1:0] WR_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [TIME_W-1:0] RD_DATA,
  output logic              RTC_CS,
  output logic              RTC_CLK,
  output logic              RTC_DIN,
  output logic              RTC_STB,
  input  logic              RTC_DOUT
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  localparam logic [7:0] STB_M1 = 8'(STROBE_LEN - 1);
  localparam int         PAD_W  = TIME_W - 4;

  state_e            state_r;
  op_e               op_r;
  logic [1:0]        stage_r;
  logic [TIME_W-1:0] tx_sr_r;
  logic [TIME_W-1:0] rx_sr_r;
  logic [5:0]        bit_cnt_r;
  logic              tmr_load_s;
  logic [7:0]        tmr_val_s;
  logic              tmr_tc_s;
  logic              rd_data_stage_s;

  assign rd_data_stage_s = (op_r == OP_READ) && (stage_r == 2'd2);

  // Reload the phase timer on every state change; only STB uses the strobe length.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = DIV_M1;
    case (state_r)
      ST_IDLE:   tmr_load_s = REQ;
      ST_FINISH: tmr_load_s = 1'b0;
      default:   tmr_load_s = tmr_tc_s;
    endcase
    if (state_r == ST_PRE) begin
      tmr_val_s = STB_M1;
    end else begin
      tmr_val_s = DIV_M1;
    end
  end

  rtc_bit_timer u_timer (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // Main sequencer; all pin and handshake outputs are registered here.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_CMD;
      stage_r   <= 2'd0;
      tx_sr_r   <= '0;
      rx_sr_r   <= '0;
      bit_cnt_r <= 6'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RD_DATA   <= '0;
      RTC_CS    <= 1'b0;
      RTC_CLK   <= 1'b0;
      RTC_DIN   <= 1'b0;
      RTC_STB   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (REQ) begin
            op_r    <= decode_op(OP);
            stage_r <= 2'd0;
            BUSY    <= 1'b1;
            RTC_CS  <= 1'b1;
            state_r <= ST_SETUP;
            case (decode_op(OP))
              OP_WRITE: begin
                tx_sr_r   <= WR_DATA;
                bit_cnt_r <= BITS_TIME;
              end
              OP_READ: begin
                tx_sr_r   <= {{PAD_W{1'b0}}, RTC_TIMEREAD};
                bit_cnt_r <= BITS_CMD;
              end
              default: begin
                tx_sr_r   <= {{PAD_W{1'b0}}, CMD};
                bit_cnt_r <= BITS_CMD;
              end
            endcase
          end
        end
        ST_SETUP: begin
          if (tmr_tc_s) begin
            state_r <= ST_BIT_LO;
            RTC_DIN <= tx_sr_r[0];
          end
        end
        ST_BIT_LO: begin
          if (tmr_tc_s) begin
            state_r <= ST_BIT_HI;
            RTC_CLK <= 1'b1;
            if (rd_data_stage_s) begin
              rx_sr_r <= {RTC_DOUT, rx_sr_r[TIME_W-1:1]};
            end
          end
        end
        ST_BIT_HI: begin
          if (tmr_tc_s) begin
            RTC_CLK <= 1'b0;
            if (bit_cnt_r != 6'd0) begin
              bit_cnt_r <= bit_cnt_r - 6'd1;
              tx_sr_r   <= {1'b0, tx_sr_r[TIME_W-1:1]};
              RTC_DIN   <= tx_sr_r[1];
              state_r   <= ST_BIT_LO;
            end else if ((op_r == OP_WRITE) && (stage_r == 2'd0)) begin
              // Time bits run straight into the TIMESET command bits.
              stage_r   <= 2'd1;
              tx_sr_r   <= {{PAD_W{1'b0}}, RTC_TIMESET};
              bit_cnt_r <= BITS_CMD;
              RTC_DIN   <= RTC_TIMESET[0];
              state_r   <= ST_BIT_LO;
            end else if (rd_data_stage_s) begin
              RD_DATA <= rx_sr_r;
              DONE    <= 1'b1;
              RTC_CS  <= 1'b0;
              RTC_DIN <= 1'b0;
              state_r <= ST_FINISH;
            end else begin
              RTC_DIN <= 1'b0;
              state_r <= ST_PRE;
            end
          end
        end
        ST_PRE: begin
          if (tmr_tc_s) begin
            RTC_STB <= 1'b1;
            state_r <= ST_STB;
          end
        end
        ST_STB: begin
          if (tmr_tc_s) begin
            RTC_STB <= 1'b0;
            state_r <= ST_POST;
          end
        end
        ST_POST: begin
          if (tmr_tc_s) begin
            if ((op_r == OP_READ) && (stage_r == 2'd0)) begin
              stage_r   <= 2'd1;
              tx_sr_r   <= {{PAD_W{1'b0}}, RTC_SHIFT};
              bit_cnt_r <= BITS_CMD;
              RTC_DIN   <= RTC_SHIFT[0];
              state_r   <= ST_BIT_LO;
            end else if ((op_r == OP_READ) && (stage_r == 2'd1)) begin
              stage_r   <= 2'd2;
              tx_sr_r   <= '0;
              bit_cnt_r <= BITS_TIME;
              RTC_DIN   <= 1'b0;
              state_r   <= ST_BIT_LO;
            end else begin
              DONE    <= 1'b1;
              RTC_CS  <= 1'b0;
              state_r <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
